// File: rtl/id_ctrl_stage_pkg.sv
// Shared RV32IM decode constants, control-bundle struct and ALU-op helpers
// for the ID control stage.
package rv32_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000, ALU_SUB    = 5'b00001, ALU_AND  = 5'b00010,
        ALU_OR     = 5'b00011, ALU_XOR    = 5'b00100, ALU_SLL  = 5'b00101,
        ALU_SRL    = 5'b00110, ALU_SRA    = 5'b00111, ALU_MUL  = 5'b01000,
        ALU_MULH   = 5'b01001, ALU_MULHU  = 5'b01010, ALU_MULHSU = 5'b01011,
        ALU_DIV    = 5'b01100, ALU_DIVU   = 5'b01101, ALU_REM  = 5'b01110,
        ALU_REMU   = 5'b01111, ALU_SLT    = 5'b10000, ALU_SLTU = 5'b10001,
        ALU_FWD    = 5'b10010
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_B = 3'b000, IMM_I = 3'b001, IMM_U = 3'b011, IMM_J = 3'b100, IMM_S = 3'b101
    } imm_sel_e;

    typedef enum logic [1:0] {
        BJ_NONE = 2'b00, BJ_JAL = 2'b01, BJ_BRANCH = 2'b10, BJ_JALR = 2'b11
    } bj_e;

    typedef struct packed {
        alu_op_e    aluop;
        imm_sel_e   imm_sel;
        logic       op1sel;
        logic       op2sel;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write_en;
        logic       wb_sel;
        bj_e        branch_jump;
        logic       jal_sel;
        logic [2:0] funct3;
    } ctrl_t;

    // alt selects SRA over SRL; only meaningful for funct3=101
    function automatic alu_op_e alu_base(input logic [2:0] f3, input logic alt);
        alu_op_e r;
        case (f3)
            3'b000:  r = ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic alu_op_e alu_muldiv(input logic [2:0] f3);
        alu_op_e r;
        case (f3)
            3'b000:  r = ALU_MUL;
            3'b001:  r = ALU_MULH;
            3'b010:  r = ALU_MULHSU;
            3'b011:  r = ALU_MULHU;
            3'b100:  r = ALU_DIV;
            3'b101:  r = ALU_DIVU;
            3'b110:  r = ALU_REM;
            default: r = ALU_REMU;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_ctrl_stage_if.sv
// IF/ID-side inputs and ID/EX-side control bundle of the decode stage.
interface id_ctrl_stage_if;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        BUSY_WAIT;
    logic        FLUSH;
    logic [4:0]  ALUOP;
    logic [2:0]  IMM_SEL;
    logic        OP1SEL;
    logic        OP2SEL;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic        REG_WRITE_EN;
    logic        WB_SEL;
    logic [1:0]  BRANCH_JUMP;
    logic        JAL_SEL;
    logic [2:0]  FUNCT3_OUT;
    logic        CTRL_VALID;
    logic        ILLEGAL;
    logic        STALL_OUT;

    modport master (
        output INSTR, INSTR_VALID, BUSY_WAIT, FLUSH,
        input  ALUOP, IMM_SEL, OP1SEL, OP2SEL, MEM_READ, MEM_WRITE, REG_WRITE_EN,
               WB_SEL, BRANCH_JUMP, JAL_SEL, FUNCT3_OUT, CTRL_VALID, ILLEGAL, STALL_OUT
    );

    modport slave (
        input  INSTR, INSTR_VALID, BUSY_WAIT, FLUSH,
        output ALUOP, IMM_SEL, OP1SEL, OP2SEL, MEM_READ, MEM_WRITE, REG_WRITE_EN,
               WB_SEL, BRANCH_JUMP, JAL_SEL, FUNCT3_OUT, CTRL_VALID, ILLEGAL, STALL_OUT
    );
endinterface

// File: rtl/id_ctrl_decode.sv
// Combinational RV32IM decoder: instruction word to control bundle plus
// illegal / multiply / divide classification.
module id_ctrl_decode
    import rv32_ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal,
    output logic        is_mul,
    output logic        is_div
);
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        ctrl        = '0;
        ctrl.funct3 = funct3;
        illegal     = 1'b0;
        is_mul      = 1'b0;
        is_div      = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl.imm_sel = IMM_U; ctrl.op2sel = 1'b1; ctrl.reg_write_en = 1'b1;
                ctrl.aluop   = ALU_FWD;
            end
            OPC_AUIPC: begin
                ctrl.imm_sel = IMM_U; ctrl.op2sel = 1'b1; ctrl.reg_write_en = 1'b1;
            end
            OPC_JAL: begin
                ctrl.imm_sel = IMM_J; ctrl.op2sel = 1'b1; ctrl.reg_write_en = 1'b1;
                ctrl.branch_jump = BJ_JAL; ctrl.jal_sel = 1'b1;
            end
            OPC_JALR: begin
                ctrl.imm_sel = IMM_I; ctrl.op1sel = 1'b1; ctrl.op2sel = 1'b1;
                ctrl.reg_write_en = 1'b1; ctrl.branch_jump = BJ_JALR; ctrl.jal_sel = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                ctrl.imm_sel = IMM_B; ctrl.op2sel = 1'b1; ctrl.branch_jump = BJ_BRANCH;
                ctrl.aluop   = ALU_SUB;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                ctrl.imm_sel = IMM_I; ctrl.op1sel = 1'b1; ctrl.op2sel = 1'b1;
                ctrl.reg_write_en = 1'b1; ctrl.wb_sel = 1'b1; ctrl.mem_read = 1'b1;
                illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                ctrl.imm_sel = IMM_S; ctrl.op1sel = 1'b1; ctrl.op2sel = 1'b1;
                ctrl.mem_write = 1'b1;
                illegal = (funct3 >= 3'b011);
            end
            OPC_OP_IMM: begin
                ctrl.imm_sel = IMM_I; ctrl.op1sel = 1'b1; ctrl.op2sel = 1'b1;
                ctrl.reg_write_en = 1'b1;
                ctrl.aluop = alu_base(funct3, instr[30]);
                // shift-immediates reuse the funct7 slot, so it must be canonical
                if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
                if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT) illegal = 1'b1;
            end
            OPC_OP: begin
                ctrl.imm_sel = IMM_B; ctrl.op1sel = 1'b1; ctrl.reg_write_en = 1'b1;
                case (funct7)
                    F7_BASE: ctrl.aluop = alu_base(funct3, 1'b0);
                    F7_ALT: begin
                        if (funct3 == 3'b000)      ctrl.aluop = ALU_SUB;
                        else if (funct3 == 3'b101) ctrl.aluop = ALU_SRA;
                        else                       illegal    = 1'b1;
                    end
                    F7_MULDIV: begin
                        if (EN_M) begin
                            ctrl.aluop = alu_muldiv(funct3);
                            is_mul     = ~funct3[2];
                            is_div     = funct3[2];
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered RV32IM decode/control stage: issues the control bundle, stalls
// upstream across multi-cycle MUL/DIV, freezes on memory busy, latches flushes.
module id_ctrl_stage
    import rv32_ctrl_pkg::*;
#(
    parameter bit EN_M    = 1'b1,
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input logic         CLK,
    input logic         RESET,
    id_ctrl_stage_if.slave bus
);
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic             dec_is_mul;
    logic             dec_is_div;

    ctrl_t            ctrl_q;
    logic             ctrl_valid_q;
    logic             illegal_q;
    logic             stall_q;
    logic [CNT_W-1:0] cnt_q;
    logic [0:0]       fsm_q;
    logic             flush_pend_q;

    id_ctrl_decode #(.EN_M(EN_M)) u_decode (
        .instr   (bus.INSTR),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .is_mul  (dec_is_mul),
        .is_div  (dec_is_div)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            stall_q      <= 1'b0;
            cnt_q        <= '0;
            fsm_q        <= ST_RUN;
            flush_pend_q <= 1'b0;
        end else if (bus.BUSY_WAIT) begin
            // frozen; remember a redirect so it is honoured once memory frees up
            if (bus.FLUSH) flush_pend_q <= 1'b1;
        end else if (bus.FLUSH || flush_pend_q) begin
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            stall_q      <= 1'b0;
            cnt_q        <= '0;
            fsm_q        <= ST_RUN;
            flush_pend_q <= 1'b0;
        end else if (fsm_q == ST_MD_WAIT && cnt_q != '0) begin
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            stall_q      <= 1'b1;
            cnt_q        <= cnt_q - CNT_W'(1);
        end else begin
            // counter drained (or RUN): the held INSTR is the next one to issue
            fsm_q        <= ST_RUN;
            stall_q      <= 1'b0;
            cnt_q        <= '0;
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            if (bus.INSTR_VALID) begin
                if (dec_illegal) begin
                    illegal_q <= 1'b1;
                end else begin
                    ctrl_q       <= dec_ctrl;
                    ctrl_valid_q <= 1'b1;
                    if (dec_is_mul && MUL_LAT > 1) begin
                        cnt_q   <= MUL_CNT;
                        stall_q <= 1'b1;
                        fsm_q   <= ST_MD_WAIT;
                    end
                    if (dec_is_div && DIV_LAT > 1) begin
                        cnt_q   <= DIV_CNT;
                        stall_q <= 1'b1;
                        fsm_q   <= ST_MD_WAIT;
                    end
                end
            end
        end
    end

    assign bus.ALUOP        = ctrl_q.aluop;
    assign bus.IMM_SEL      = ctrl_q.imm_sel;
    assign bus.OP1SEL       = ctrl_q.op1sel;
    assign bus.OP2SEL       = ctrl_q.op2sel;
    assign bus.MEM_READ     = ctrl_q.mem_read;
    assign bus.MEM_WRITE    = ctrl_q.mem_write;
    assign bus.REG_WRITE_EN = ctrl_q.reg_write_en;
    assign bus.WB_SEL       = ctrl_q.wb_sel;
    assign bus.BRANCH_JUMP  = ctrl_q.branch_jump;
    assign bus.JAL_SEL      = ctrl_q.jal_sel;
    assign bus.FUNCT3_OUT   = ctrl_q.funct3;
    assign bus.CTRL_VALID   = ctrl_valid_q;
    assign bus.ILLEGAL      = illegal_q;
    assign bus.STALL_OUT    = stall_q;

endmodule

// File: doc/id_ctrl_stage.md
Name: id_ctrl_stage

Overview:
- Registered decode/control stage of the RV32IM pipeline, sitting between the IF/ID register and the ID/EX register.
- Decodes the full 32-bit instruction into the control bundle: ALU op, immediate select, operand selects, memory, writeback, branch/jump.
- Adds illegal-instruction detection, a build-time M-extension enable, and distinct JAL/JALR encoding.
- Handles multi-cycle MUL/DIV issue stalls, memory-busy freeze and pipeline flush with a pending-flush latch.

Parameters:
- EN_M, 1: 1 decodes RV32M; 0 flags all M opcodes as illegal.
- MUL_LAT, 1: EX cycles for MUL/MULH/MULHSU/MULHU, range 1..15.
- DIV_LAT, 32: EX cycles for DIV/DIVU/REM/REMU, range 1..63.
- CNT_W, 6: stall counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- CLK, in, 1: clock, rising edge.
- RESET, in, 1: synchronous, active-high.
- INSTR, in, 32: instruction from IF/ID.
- INSTR_VALID, in, 1: INSTR holds a real instruction.
- BUSY_WAIT, in, 1: memory stall; freezes the stage.
- FLUSH, in, 1: branch/jump redirect; kill the instruction in decode.
- ALUOP, out, 5: ALU operation.
- IMM_SEL, out, 3: immediate format.
- OP1SEL, out, 1: 0=PC, 1=rs1.
- OP2SEL, out, 1: 0=rs2, 1=imm.
- MEM_READ, out, 1: load.
- MEM_WRITE, out, 1: store.
- REG_WRITE_EN, out, 1: register writeback.
- WB_SEL, out, 1: 0=ALU, 1=memory.
- BRANCH_JUMP, out, 2: 00 none, 01 JAL, 10 branch, 11 JALR.
- JAL_SEL, out, 1: write PC+4 to rd.
- FUNCT3_OUT, out, 3: funct3 passthrough for branch and load/store width.
- CTRL_VALID, out, 1: the bundle is live.
- ILLEGAL, out, 1: the decoded instruction is illegal.
- STALL_OUT, out, 1: hold IF/ID and PC.

Behaviour:
- All outputs are registered: one cycle from INSTR to the bundle.
- Reset value of every output is 0. Registered 0 state is the "bubble"; FSM=RUN, counter=0, pending-flush=0.
- Priority each edge: RESET > BUSY_WAIT > FLUSH > STALL (counter≠0) > normal decode.
- BUSY_WAIT=1:
  - All outputs, the counter and the FSM hold their values.
  - If FLUSH=1 in the same cycle, set pending-flush.
- First edge with BUSY_WAIT=0 and (FLUSH or pending-flush):
  - Load the bubble; clear the counter, pending-flush and STALL_OUT; FSM->RUN.
  - A flush aborts any MUL/DIV stall.
- FSM RUN, INSTR_VALID=0: load the bubble.
- FSM RUN, INSTR_VALID=1: load the decoded bundle, CTRL_VALID=1, ILLEGAL=0.
  - If the instruction is M-type with latency L>1: counter <= L-1, STALL_OUT<=1, FSM->MD_WAIT.
- FSM MD_WAIT:
  - Each non-busy edge: counter decrements; outputs go to the bubble (no duplicate issue); STALL_OUT stays 1.
  - Counter reaching 0 clears STALL_OUT, FSM->RUN.
  - Upstream holds INSTR, which is the next instruction.
- Illegal instructions load the bubble with ILLEGAL=1 and CTRL_VALID=0 for one cycle. An instruction is illegal when:
  - the opcode is unknown, or
  - R-type funct7 is not in {0000000, 0100000, 0000001}, or
  - funct7=0100000 with funct3 not in {000, 101}, or
  - SLLI/SRLI/SRAI have a bad funct7, or
  - funct7=0000001 with EN_M=0, or
  - the branch funct3 is 010 or 011, or
  - the load funct3 is 011, 110 or 111, or
  - the store funct3 is ≥011, or
  - JALR funct3≠000.
- Decode fields, per instruction (IMM_SEL/OP1/OP2/REG_WRITE_EN/WB/MEM_READ/MEM_WRITE/BRANCH_JUMP/JAL_SEL/ALUOP):
  - LUI: U/x/1/1/0/0/0/00/0/FWD.
  - AUIPC: U/0/1/1/0/0/0/00/0/ADD.
  - JAL: J/0/1/1/0/0/0/01/1/ADD.
  - JALR: I/1/1/1/0/0/0/11/1/ADD.
  - Branch: B/0/1/0/x/0/0/10/0/SUB.
  - Load: I/1/1/1/1/1/0/00/0/ADD.
  - Store: S/1/1/0/x/0/1/00/0/ADD.
  - OP-IMM: I/1/1/1/0/0/0/00/0, ALUOP from funct3 and INSTR[30].
  - OP: R(000)/1/0/1/0/0/0/00/0, ALUOP from {funct7, funct3}.
- Bubble fields: x-outputs are driven 0.

Decomposition:
- Package rv32_ctrl_pkg holds:
  - Opcode constants.
  - ALUOP codes: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLL 00101, SRL 00110, SRA 00111, MUL 01000, MULH 01001, MULHU 01010, MULHSU 01011, DIV 01100, DIVU 01101, REM 01110, REMU 01111, SLT 10000, SLTU 10001, FWD 10010.
  - IMM_SEL codes: B 000, I 001, U 011, J 100, S 101.
  - BRANCH_JUMP codes.
- One sub-module, id_ctrl_decode: purely combinational INSTR -> {bundle, illegal, is_mul, is_div}. The stage adds the FSM, counter and registers.

Test Plan:
- RESET, then ADD x3,x1,x2 (0x002081B3) valid -> next cycle ALUOP=00000, OP2SEL=0, REG_WRITE_EN=1, CTRL_VALID=1.
- DIV (0x0220C1B3) with DIV_LAT=4 -> bundle 01100 for 1 cycle, STALL_OUT=1 for 4 cycles, then 3 bubbles, then the next instruction issues.
- DIV in progress, FLUSH at stall cycle 2 -> bubble next edge, STALL_OUT=0, FSM RUN.
- BUSY_WAIT=1 for 3 cycles with FLUSH pulsed in the 2nd -> outputs frozen; first non-busy edge gives the bubble.
- MUL with EN_M=0, opcode 0x7F, and funct7=0100000 with funct3=001 -> each gives ILLEGAL=1, CTRL_VALID=0, all enables 0.
- JALR (0x000080E7) -> BRANCH_JUMP=11, OP1SEL=1, JAL_SEL=1; JAL (0x004000EF) -> BRANCH_JUMP=01, OP1SEL=0.
